// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: flag 0111110, then a bit-stuffed MSB-first payload on sout.
// Define SERIAL_FRAME_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              sout,
    output logic              busy,
    output logic              done
);
    // Handshake: a word is taken on any posedge where valid && ready; ready is high only in IDLE.
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = ($clog2(DATA_W + 1) > 3) ? $clog2(DATA_W + 1) : 3;
    localparam logic [6:0]    FLAG_PAT = 7'b0111110;
    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLAG   = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STUFF  = 3'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     timer;
    logic [2:0]        ones;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              par_bit;
    logic              par_done;
`endif

    logic       tick;
    logic       data_left;
    logic [2:0] ones_next;

    assign tick      = (timer == T_LAST);
    assign data_left = (cnt < CW'(DATA_W));
    // sout is the bit currently on the line, so it decides the run length after this slot.
    assign ones_next = sout ? (ones + 3'd1) : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            shreg    <= '0;
            cnt      <= '0;
            timer    <= '0;
            ones     <= '0;
            sout     <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_bit  <= 1'b0;
            par_done <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state != S_IDLE)
                timer <= tick ? '0 : timer + TW'(1);
            case (state)
                S_IDLE: begin
                    sout <= 1'b0;
                    if (valid && ready) begin
                        state    <= S_FLAG;
                        shreg    <= data_in;
                        cnt      <= '0;
                        timer    <= '0;
                        ones     <= '0;
                        sout     <= FLAG_PAT[6];
                        busy     <= 1'b1;
                        ready    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        par_bit  <= ^data_in;
                        par_done <= 1'b0;
`endif
                    end
                end
                S_FLAG: begin
                    if (tick) begin
                        if (cnt == CW'(6)) begin
                            // Flag ends in 0, so the run of ones starts fresh with the payload.
                            state <= S_DATA;
                            sout  <= shreg[DATA_W-1];
                            shreg <= shreg << 1;
                            cnt   <= CW'(1);
                            ones  <= '0;
                        end else begin
                            cnt  <= cnt + CW'(1);
                            sout <= FLAG_PAT[3'd5 - cnt[2:0]];
                        end
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                S_DATA, S_STUFF, S_PARITY: begin
`else
                S_DATA, S_STUFF: begin
`endif
                    if (tick) begin
                        if (ones_next == 3'd4) begin
                            state <= S_STUFF;
                            sout  <= 1'b0;
                            ones  <= '0;
                        end else begin
                            ones <= ones_next;
                            if (data_left) begin
                                state <= S_DATA;
                                sout  <= shreg[DATA_W-1];
                                shreg <= shreg << 1;
                                cnt   <= cnt + CW'(1);
                            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            else if (!par_done) begin
                                state    <= S_PARITY;
                                sout     <= par_bit;
                                par_done <= 1'b1;
                            end
`endif
                            else begin
                                state <= S_IDLE;
                                sout  <= 1'b0;
                                busy  <= 1'b0;
                                ready <= 1'b1;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                    cnt   <= '0;
                    ones  <= '0;
                    sout  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
